imm_extend_pipe: RTL
====================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each immediate.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid  in  1 and in_ready  out  1, forming the input handshake.
REQ-006 SHALL have port in_instr  in  32  raw instruction word.
REQ-007 SHALL have port in_sel  in  3  immediate format selector.
REQ-008 SHALL have port in_tag  in  TAG_W  sideband, passed through unmodified.
REQ-009 SHALL have ports out_valid  out  1 and out_ready  in  1, forming the output handshake.
REQ-010 SHALL have port out_imm  out  XLEN  extended immediate.
REQ-011 SHALL have port out_tag  out  TAG_W  tag paired with out_imm.
REQ-012 SHALL have port out_illegal  out  1  asserted when the entry used reserved selector 7.
REQ-013 SHALL have port err_count  out  8  saturating count of accepted illegal-selector entries.

Function
REQ-014 SHALL accept an entry only when in_valid && in_ready; SHALL retire it only when out_valid && out_ready.
REQ-015 SHALL decode in_sel as: 0 I {sx,instr[31:20]}; 1 S {sx,instr[31:25],instr[11:7]}; 2 B {sx,instr[31],instr[7],instr[30:25],instr[11:8],0}; 3 U {sx,instr[31:12],12'b0}; 4 J {sx,instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-016 sx = instr[31] replicated to fill XLEN bits; U and J SHALL be sign-extended to XLEN as well.
REQ-017 SHALL decode 5 ZIMM: instr[19:15] zero-extended; 6 SHAMT: instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64), zero-extended.
REQ-018 SHALL decode selector 7 as imm 0 with out_illegal=1; every other selector SHALL give out_illegal=0.
REQ-019 SHALL present an accepted entry on out_* exactly 1 cycle after acceptance when the output stage is empty.
REQ-020 SHALL hold out_imm, out_tag and out_illegal stable while out_valid && !out_ready.
REQ-021 SHALL deliver entries in acceptance order; SHALL never drop or duplicate an entry.
REQ-022 Without the skid buffer, in_ready SHALL equal !out_valid || out_ready; accept and retire in the same cycle SHALL be permitted.
REQ-023 err_count SHALL increment by 1 on each accepted entry with in_sel==7, SHALL saturate at 255, and SHALL never wrap.

Reset
REQ-024 While rst is high, out_valid SHALL be 0, err_count 0, the skid buffer empty, and out_imm, out_tag and out_illegal 0.
REQ-025 in_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight entries, so no entry surfaces after reset.

Configuration
REQ-027 With IMM_EXTEND_SKID_EN defined, the block SHALL add a one-entry skid register.
  - in_ready SHALL be a register output equal to !skid_full.
  - An entry accepted while out_valid && !out_ready SHALL enter the skid register.
  - The skid entry SHALL move to the output stage on the next retire.
  - Full throughput SHALL be kept with no combinational in_ready-to-out_ready path.
REQ-028 Without IMM_EXTEND_SKID_EN, the block SHALL be a single pipeline register and behave per REQ-022.

Structure
REQ-029 Package imm_pkg SHALL hold the imm_sel_t enum (IMM_I..IMM_RSVD, 3-bit) and the default XLEN constant.
REQ-030 The combinational decode SHALL be sub-module imm_format_decode (instr, sel -> imm, illegal).
REQ-031 imm_extend_pipe SHALL hold only the handshake, storage and counter logic.

Verification
REQ-032 Bench SHALL cover: instr 0xFFF00093, sel 0, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, out_illegal 0.
REQ-033 Bench SHALL cover: 0xFE000EE3 sel 2 -> 0xFFFFFFFC; 0x12345037 sel 3 -> 0x12345000; 0x0080006F sel 4 -> 0x00000008.
REQ-034 Bench SHALL cover: XLEN=64, 0x80000037 sel 3 -> 0xFFFFFFFF80000000; 0x03F01013 sel 6 -> 0x3F.
REQ-035 Bench SHALL cover backpressure: out_ready=0 for 4 cycles, in_valid=1 with tags 1,2,3.
  - With SKID: 2 accepted, then in_ready=0; after release, tags retire 1,2,3 in order.
  - Without SKID: 1 accepted, then in_ready=0.
REQ-036 Bench SHALL cover: 300 accepted entries with sel 7 -> err_count reaches 255 and holds; each out_imm 0 with out_illegal 1.
REQ-037 Bench SHALL cover: rst pulsed 1 cycle while out_valid=1 and skid full -> next cycle out_valid 0, err_count 0, and no stale tag ever appears.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the immediate extension pipe
// Purpose: immediate format selector encoding and the default output width.
// Ports: none (package).
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_ZIMM  = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_sel_t;

endpackage

// File: rtl/imm_format_decode.sv
// rtl/imm_format_decode.sv - combinational immediate field extraction and extension
// Purpose: pull the immediate for the selected format out of an instruction word
//          and extend it to XLEN bits.
// Ports:
//   instr   in  32    raw instruction word
//   sel     in  3     immediate format selector (imm_sel_t)
//   imm     out XLEN  extended immediate
//   illegal out 1     reserved selector used
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  imm_sel_t        sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Signed formats are first assembled as a 32-bit two's complement value and
  // then sign-extended to XLEN, so U and J also extend on 64-bit builds.
  logic [31:0] v32;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    v32     = '0;
    imm     = '0;
    illegal = 1'b0;
    case (sel)
      IMM_I: begin
        v32 = {{20{instr[31]}}, instr[31:20]};
        imm = XLEN'($signed(v32));
      end
      IMM_S: begin
        v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm = XLEN'($signed(v32));
      end
      IMM_B: begin
        v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm = XLEN'($signed(v32));
      end
      IMM_U: begin
        v32 = {instr[31:12], 12'b0};
        imm = XLEN'($signed(v32));
      end
      IMM_J: begin
        v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm = XLEN'($signed(v32));
      end
      IMM_ZIMM: begin
        imm = XLEN'(instr[19:15]);
      end
      IMM_SHAMT: begin
        // 64-bit shifts need a sixth shift-amount bit.
        if (XLEN == 64) imm = XLEN'(instr[25:20]);
        else            imm = XLEN'(instr[24:20]);
      end
      IMM_RSVD: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - valid/ready pipeline stage around imm_format_decode
// Purpose: register decoded immediates with a sideband tag and count
//          reserved-selector entries. Optional one-entry skid register when
//          IMM_EXTEND_SKID_EN is defined.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake
//   in_instr, in_sel       instruction word and format selector
//   in_tag                 sideband carried with the entry
//   out_valid/out_ready    output handshake
//   out_imm, out_tag       extended immediate and its tag
//   out_illegal            entry used the reserved selector
//   err_count              saturating count of accepted reserved-selector entries
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [7:0]       err_count
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            accept;
  logic            retire;

  imm_format_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .sel     (imm_sel_t'(in_sel)),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;

`ifdef IMM_EXTEND_SKID_EN
  logic             skid_full;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;

  // in_ready depends only on local state (and reset), never on out_ready.
  assign in_ready = !rst && !skid_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      skid_full    <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (skid_full) begin
      // No accept is possible here; the older output entry leaves first.
      if (retire) begin
        out_imm     <= skid_imm;
        out_tag     <= skid_tag;
        out_illegal <= skid_illegal;
        skid_full   <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_valid   <= 1'b1;
        out_imm     <= dec_imm;
        out_tag     <= in_tag;
        out_illegal <= dec_illegal;
      end else begin
        skid_full    <= 1'b1;
        skid_imm     <= dec_imm;
        skid_tag     <= in_tag;
        skid_illegal <= dec_illegal;
      end
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_imm     <= dec_imm;
      out_tag     <= in_tag;
      out_illegal <= dec_illegal;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && (in_sel == 3'd7) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule
